// File: rtl/rr_arb8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Imported by the interface, the encoder wrapper and the arbiter top.
package rr_arb8_pkg;

    localparam int ARB_N        = 8;
    localparam int ARB_IDX_W    = 3;
    localparam int DEF_MAX_HOLD = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Everything the arbiter drives, kept as one registered bundle
    typedef struct packed {
        logic [ARB_N-1:0]     gnt;
        logic [ARB_IDX_W-1:0] gnt_id;
        logic                 gnt_valid;
        logic                 timeout;
        logic                 busy;
    } arb_out_t;

    function automatic logic [ARB_N-1:0] onehot(input logic [ARB_IDX_W-1:0] idx);
        logic [ARB_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic int hold_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Request side drives enable/req/done; arbiter side drives grant and status.
interface rr_arb8_if;
    import rr_arb8_pkg::*;

    logic                 enable;
    logic [ARB_N-1:0]     req;
    logic                 done;
    logic [ARB_N-1:0]     gnt;
    logic [ARB_IDX_W-1:0] gnt_id;
    logic                 gnt_valid;
    logic                 timeout;
    logic                 busy;

    modport master (
        output enable, req, done,
        input  gnt, gnt_id, gnt_valid, timeout, busy
    );

    modport slave (
        input  enable, req, done,
        output gnt, gnt_id, gnt_valid, timeout, busy
    );

endinterface

// File: rtl/rr_arb8_prio_enc8.sv
// Purpose: 8-bit highest-set-bit priority encoder; idx=0, any=0 for zero input.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module prio_enc8 (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       any
);

    always_comb begin
        idx = 3'd0;
        any = |vec;
        // Ascending scan: the last set bit seen is the highest one
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// Purpose: 8-requester round-robin arbiter, one-hot grant held until done/drop/timeout.
// Latency: grant one cycle after a sampled request; one gnt=0 RELEASE cycle between owners.
// Backpressure: enable=0 blocks new grants only; an active grant runs to completion.
module rr_arb8
    import rr_arb8_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic      clk,
    input  logic      rst_n,
    rr_arb8_if.slave  bus
);

    localparam int                HOLD_W   = hold_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_t               state_q, state_d;
    logic [ARB_IDX_W-1:0] start_q, start_d;
    logic [HOLD_W-1:0]    hold_q,  hold_d;
    arb_out_t             out_q,   out_d;

    logic [ARB_N-1:0]     rot_req;
    logic [ARB_IDX_W-1:0] enc_idx;
    logic                 enc_any;
    logic [ARB_IDX_W-1:0] winner;

    logic at_limit;
    logic owner_drop;
    logic release_now;

    // Rotate so requester 'start' sits at bit 7, start-1 at bit 6, and so on
    always_comb begin
        rot_req = '0;
        for (int j = 0; j < ARB_N; j++) begin
            rot_req[j] = bus.req[ARB_IDX_W'(j) + start_q + 3'd1];
        end
    end

    prio_enc8 u_enc (
        .vec (rot_req),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign winner = enc_idx + start_q + 3'd1;

    assign at_limit    = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);
    assign owner_drop  = !bus.req[out_q.gnt_id];
    assign release_now = bus.done || owner_drop || at_limit;

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        hold_d        = hold_q;
        out_d         = out_q;
        out_d.timeout = 1'b0;

        case (state_q)
            IDLE: begin
                out_d.busy = 1'b0;
                if (bus.enable && enc_any) begin
                    state_d         = GRANT;
                    out_d.gnt       = onehot(winner);
                    out_d.gnt_id    = winner;
                    out_d.gnt_valid = 1'b1;
                    out_d.busy      = 1'b1;
                    hold_d          = HOLD_ONE;
                end
            end

            GRANT: begin
                if (release_now) begin
                    state_d         = RELEASE;
                    out_d.gnt       = '0;
                    out_d.gnt_valid = 1'b0;
                    out_d.busy      = 1'b1;
                    // Timeout only flags a release that nothing else asked for
                    out_d.timeout   = at_limit && !bus.done && !owner_drop;
                    start_d         = out_q.gnt_id - 3'd1;
                    hold_d          = '0;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end

            RELEASE: begin
                state_d    = IDLE;
                out_d.busy = 1'b0;
            end

            default: begin
                state_d = IDLE;
                out_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 3'd7;
            hold_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
        end
    end

    assign bus.gnt       = out_q.gnt;
    assign bus.gnt_id    = out_q.gnt_id;
    assign bus.gnt_valid = out_q.gnt_valid;
    assign bus.timeout   = out_q.timeout;
    assign bus.busy      = out_q.busy;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8 built with MAX_HOLD=4; expected values are hand-derived.
module tb_rr_arb8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_arb8_if bus ();

    rr_arb8 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_busy, input logic exp_to);
        chk({tag, ".gnt"},     32'(bus.gnt),       32'h0);
        chk({tag, ".valid"},   32'(bus.gnt_valid), 32'h0);
        chk({tag, ".busy"},    32'(bus.busy),      32'(exp_busy));
        chk({tag, ".timeout"}, 32'(bus.timeout),   32'(exp_to));
    endtask

    task automatic chk_grant(input string tag, input int id);
        chk({tag, ".gnt"},   32'(bus.gnt),       32'(1) << id);
        chk({tag, ".id"},    32'(bus.gnt_id),    32'(id));
        chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'h1);
        chk({tag, ".busy"},  32'(bus.busy),      32'h1);
    endtask

    // From IDLE: grant, hold one more cycle, done in cycle 2, RELEASE, back to IDLE
    task automatic grant_with_done(input string tag, input int id);
        tick();
        chk_grant({tag, ".g1"}, id);
        tick();
        chk_grant({tag, ".g2"}, id);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_idle({tag, ".rel"}, 1'b1, 1'b0);
        tick();
        chk_idle({tag, ".idle"}, 1'b0, 1'b0);
    endtask

    initial begin
        int seq_ff [9];
        int seq_21 [4];
        total = 0;
        bad   = 0;
        seq_ff = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        seq_21 = '{5, 0, 5, 0};

        // Reset
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.req    = 8'h00;
        bus.done   = 1'b0;
        tick();
        tick();
        chk_idle("rst", 1'b0, 1'b0);
        chk("rst.id", 32'(bus.gnt_id), 32'h0);
        rst_n = 1'b1;

        // Single requester 0, released by dropping req
        bus.enable = 1'b1;
        bus.req    = 8'h01;
        tick();
        chk_grant("single", 0);
        bus.req = 8'h00;
        tick();
        chk_idle("single.rel", 1'b1, 1'b0);
        tick();
        chk_idle("single.idle", 1'b0, 1'b0);

        // All requesting: descending rotation wrapping back to 7
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            grant_with_done($sformatf("ff%0d", i), seq_ff[i]);
        end

        // Two requesters alternate, absent bits never granted
        bus.req = 8'h21;
        for (int i = 0; i < 4; i++) begin
            grant_with_done($sformatf("p21_%0d", i), seq_21[i]);
        end

        // Timeout: owner 3 held 4 cycles then force-released
        bus.req = 8'h08;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk_grant($sformatf("to.c%0d", c), 3);
            chk($sformatf("to.c%0d.timeout", c), 32'(bus.timeout), 32'h0);
        end
        tick();
        chk_idle("to.rel", 1'b1, 1'b1);
        tick();
        chk_idle("to.idle", 1'b0, 1'b0);

        // Re-grant to 3; done on the limit cycle suppresses timeout
        tick();
        chk_grant("lim.c1", 3);
        tick();
        tick();
        tick();
        chk_grant("lim.c4", 3);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_idle("lim.rel", 1'b1, 1'b0);
        tick();
        chk_idle("lim.idle", 1'b0, 1'b0);

        // Reset mid-grant of owner 6, then pointer restarts at 7
        bus.req = 8'h40;
        tick();
        chk_grant("mid", 6);
        chk("mid.gnt40", 32'(bus.gnt), 32'h40);
        rst_n   = 1'b0;
        bus.req = 8'hFF;
        tick();
        chk_idle("mid.rst", 1'b0, 1'b0);
        chk("mid.rst.id", 32'(bus.gnt_id), 32'h0);
        rst_n = 1'b1;
        tick();
        chk_grant("post_rst", 7);

        // enable drop mid-grant: owner kept until done, then nothing granted
        bus.enable = 1'b0;
        tick();
        chk_grant("en.c2", 7);
        tick();
        chk_grant("en.c3", 7);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_idle("en.rel", 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_idle($sformatf("en.off%0d", c), 1'b0, 1'b0);
        end
        bus.enable = 1'b1;
        tick();
        chk_grant("en.back", 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arb8.md
Name: rr_arb8

Overview:
- Round-robin arbiter that shares one downstream resource between 8 requesters.
- Grants are one-hot, held until the owner finishes, withdraws, or times out.
- The next owner is chosen by a rotating-priority search built on an 8-bit highest-bit-first priority encoder.
- Sits between the request sources and the shared datapath unit.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; 0 disables the timeout.
- HOLD_W, $clog2(MAX_HOLD+1) (min 1), hold counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- enable  input  1  allows new grants; does not cut off an active grant
- req  input  8  request vector, bit i = requester i
- done  input  1  resource finished for current owner, single-cycle pulse
- gnt  output  8  one-hot grant, all zeros when no owner
- gnt_id  output  3  index of current owner, valid only when gnt_valid=1
- gnt_valid  output  1  OR of gnt
- timeout  output  1  one-cycle pulse when a grant is force-released
- busy  output  1  1 in GRANT or RELEASE state

Behaviour:
- Clocking and reset:
  - One clock domain (clk); reset is synchronous and active-low (rst_n).
  - All outputs and state are registered.
  - rst_n=0 at any edge, including mid-grant: state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, busy=0, start=7, hold_cnt=0.
- Search order:
  - Start index s (3 bits) is tried first, then s-1, s-2 … wrapping 0→7, ending at s+1.
  - Implementation: rotate req so bit s lands at bit 7, feed the priority encoder, and add back the offset mod 8.
- After granting k, s becomes (k-1) mod 8. Result: descending rotation, starting at 7 after reset.
- IDLE:
  - If enable=1 and req≠0 at edge N, then at edge N+1: gnt=onehot(winner), gnt_id=winner, gnt_valid=1, busy=1, hold_cnt=1, state=GRANT.
  - Grant latency is one cycle from a sampled request.
  - Otherwise remain in IDLE.
- GRANT release conditions, evaluated each edge on registered state:
  - done=1, or
  - req[gnt_id]=0, or
  - MAX_HOLD≠0 and hold_cnt==MAX_HOLD.
  - Any condition true: next state=RELEASE, gnt=0, gnt_valid=0, s updated.
  - Otherwise hold_cnt increments and the grant holds.
- Timeout:
  - Pulses for exactly the RELEASE cycle only when the timeout was the sole release cause.
  - Simultaneous done or req drop with the counter limit counts as a normal release, timeout=0.
- Grant duration is at most MAX_HOLD cycles.
- RELEASE: one idle-gap cycle, busy=1, gnt=0. Next state is IDLE, which arbitrates normally. There is always at least one cycle of gnt=0 between consecutive owners.
- enable=0 during GRANT: the current grant completes normally; no new grant until enable=1.
- Changes to req bits other than the owner's have no effect during GRANT.
- A requester that drops and re-asserts req gets no priority boost; only the s pointer decides.
- done in IDLE or RELEASE is ignored.
- X on req is not handled; the bench drives known values.

Decomposition:
- Shared package: ARB_N=8, ARB_IDX_W=3, state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2), default MAX_HOLD constant.
- One sub-module: prio_enc8, 8-bit highest-set-bit encoder with outputs idx[2:0] and any. It is instantiated once inside rr_arb8. It returns 0 with any=0 for an all-zero input.

Test Plan:
- Reset, enable=1, req=8'b0000_0001 → next cycle gnt=8'h01, gnt_id=0, busy=1; drop req → one RELEASE cycle, then idle, busy=0.
- req=8'hFF held, done pulsed on each grant's 2nd cycle → gnt_id sequence 7,6,5,4,3,2,1,0,7, separated by one gnt=0 cycle each.
- req=8'b0010_0001 held, done each grant → gnt_id alternates 5,0,5,0; never grants absent bits.
- MAX_HOLD=4, req=8'h08 held, no done → gnt=8'h08 for exactly 4 cycles, timeout=1 for 1 cycle, re-grant to 3 after the gap.
- MAX_HOLD=4, done asserted on the 4th grant cycle → release, timeout stays 0.
- rst_n=0 for one edge during GRANT with gnt=8'h40 → next cycle all outputs zero, state IDLE; next grant with req=8'hFF is id 7.
- enable dropped mid-grant → current owner held until done; then no grants while enable=0 despite req=8'hFF.
